// File: rtl/eth_stats_pkg.sv
// Shared types, constants and helpers for the per-port packet statistics engine.
// Used by eth_port_stat_chan and eth_port_pkt_stats.
package eth_stats_pkg;

    typedef enum logic [1:0] {
        STAT_PKT   = 2'd0,
        STAT_BCAST = 2'd1,
        STAT_BYTE  = 2'd2,
        STAT_RUNT  = 2'd3
    } stat_sel_e;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_e;

    localparam logic [47:0] BCAST_MAC  = 48'hFFFF_FFFF_FFFF;
    localparam int          LEN_W      = 16;
    localparam int          MAX_KEEP_W = 128;

    // tkeep is contiguous from the LSB, but a plain popcount is just as cheap and
    // tolerates a malformed keep without miscounting wildly.
    function automatic logic [LEN_W-1:0] keep_popcount(input logic [MAX_KEEP_W-1:0] keep);
        logic [LEN_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            n = n + LEN_W'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/eth_port_stat_chan.sv
// One port: frame FSM, 16-bit saturating length, PKT/BCAST/BYTE/RUNT counters.
// Counters move 1 cycle after the tlast-beat edge; purely passive, no backpressure.
module eth_port_stat_chan
    import eth_stats_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int CNT_W      = 32,
    parameter int BYTE_CNT_W = 48,
    parameter int SATURATE   = 1,
    parameter int RUNT_LEN   = 64
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    input  logic [47:0]           dst_mac,
    input  logic [DATA_W/8-1:0]   tkeep,
    input  logic                  tvalid,
    input  logic                  tready,
    input  logic                  tlast,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic [CNT_W-1:0]      bcast_cnt,
    output logic [BYTE_CNT_W-1:0] byte_cnt,
    output logic [CNT_W-1:0]      runt_cnt
);

    localparam logic [LEN_W:0] RUNT_THR = (LEN_W+1)'(RUNT_LEN);

    pkt_state_e            state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  bcast_q, bcast_d;
    logic                  done_q, done_d;
    logic [LEN_W-1:0]      done_len_q, done_len_d;
    logic                  done_bcast_q, done_bcast_d;
    logic [CNT_W-1:0]      pkt_q, pkt_d;
    logic [CNT_W-1:0]      bcast_cnt_q, bcast_cnt_d;
    logic [CNT_W-1:0]      runt_q, runt_d;
    logic [BYTE_CNT_W-1:0] byte_q, byte_d;

    logic                  beat;
    logic [LEN_W-1:0]      pop;
    logic [LEN_W:0]        len_sum;
    logic [LEN_W-1:0]      len_next;
    logic                  frame_bcast;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W:0] s;
        s = {1'b0, v} + (CNT_W+1)'(1);
        if (s[CNT_W] && SATURATE != 0) return '1;
        return s[CNT_W-1:0];
    endfunction

    function automatic logic [BYTE_CNT_W-1:0] byte_add(input logic [BYTE_CNT_W-1:0] v,
                                                       input logic [LEN_W-1:0]      n);
        logic [BYTE_CNT_W:0] s;
        s = {1'b0, v} + (BYTE_CNT_W+1)'(n);
        if (s[BYTE_CNT_W] && SATURATE != 0) return '1;
        return s[BYTE_CNT_W-1:0];
    endfunction

    always_comb begin
        beat        = tvalid & tready;
        pop         = keep_popcount(MAX_KEEP_W'(tkeep));
        len_sum     = (state_q == IDLE) ? {1'b0, pop} : ({1'b0, len_q} + {1'b0, pop});
        len_next    = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
        frame_bcast = (state_q == IDLE) ? (dst_mac == BCAST_MAC) : bcast_q;

        state_d      = state_q;
        len_d        = len_q;
        bcast_d      = bcast_q;
        done_d       = 1'b0;
        done_len_d   = done_len_q;
        done_bcast_d = done_bcast_q;
        if (beat) begin
            len_d   = len_next;
            bcast_d = frame_bcast;
            if (tlast) begin
                state_d      = IDLE;
                done_d       = 1'b1;
                done_len_d   = len_next;
                done_bcast_d = frame_bcast;
            end else begin
                state_d = IN_PKT;
            end
        end
    end

    // Clear takes priority over a completion landing in the same cycle.
    always_comb begin
        pkt_d       = pkt_q;
        bcast_cnt_d = bcast_cnt_q;
        runt_d      = runt_q;
        byte_d      = byte_q;
        if (cnt_clr) begin
            pkt_d       = '0;
            bcast_cnt_d = '0;
            runt_d      = '0;
            byte_d      = '0;
        end else if (done_q) begin
            pkt_d  = cnt_inc(pkt_q);
            byte_d = byte_add(byte_q, done_len_q);
            if (done_bcast_q)                      bcast_cnt_d = cnt_inc(bcast_cnt_q);
            if ({1'b0, done_len_q} < RUNT_THR)     runt_d      = cnt_inc(runt_q);
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q      <= IDLE;
            len_q        <= '0;
            bcast_q      <= 1'b0;
            done_q       <= 1'b0;
            done_len_q   <= '0;
            done_bcast_q <= 1'b0;
            pkt_q        <= '0;
            bcast_cnt_q  <= '0;
            runt_q       <= '0;
            byte_q       <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            bcast_q      <= bcast_d;
            done_q       <= done_d;
            done_len_q   <= done_len_d;
            done_bcast_q <= done_bcast_d;
            pkt_q        <= pkt_d;
            bcast_cnt_q  <= bcast_cnt_d;
            runt_q       <= runt_d;
            byte_q       <= byte_d;
        end
    end

    assign pkt_cnt   = pkt_q;
    assign bcast_cnt = bcast_cnt_q;
    assign byte_cnt  = byte_q;
    assign runt_cnt  = runt_q;

endmodule

// File: rtl/eth_port_pkt_stats.sv
// Per-port AXI-S packet statistics with registered read port (1-cycle read latency);
// passive tap, never drives tready. Optional shadow snapshot via PKT_STATS_SNAPSHOT_EN.
module eth_port_pkt_stats
    import eth_stats_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_W     = 64,
    parameter int CNT_W      = 32,
    parameter int BYTE_CNT_W = 48,
    parameter int SATURATE   = 1,
    parameter int RUNT_LEN   = 64
) (
    input  logic                                   axis_aclk,
    input  logic                                   axis_aresetn,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]       mon_tdata,
    input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]     mon_tkeep,
    input  logic [NUM_PORTS-1:0]                   mon_tvalid,
    input  logic [NUM_PORTS-1:0]                   mon_tready,
    input  logic [NUM_PORTS-1:0]                   mon_tlast,
    input  logic                                   CntClr,
`ifdef PKT_STATS_SNAPSHOT_EN
    input  logic                                   snap,
`endif
    input  logic                                   rd_en,
    input  logic [$clog2(NUM_PORTS)+1:0]           rd_addr,
    output logic [63:0]                            rd_data,
    output logic                                   rd_valid
);

    localparam int ADDR_W = $clog2(NUM_PORTS) + 2;

    logic [CNT_W-1:0]      live_pkt   [NUM_PORTS];
    logic [CNT_W-1:0]      live_bcast [NUM_PORTS];
    logic [BYTE_CNT_W-1:0] live_byte  [NUM_PORTS];
    logic [CNT_W-1:0]      live_runt  [NUM_PORTS];

    logic [CNT_W-1:0]      src_pkt    [NUM_PORTS];
    logic [CNT_W-1:0]      src_bcast  [NUM_PORTS];
    logic [BYTE_CNT_W-1:0] src_byte   [NUM_PORTS];
    logic [CNT_W-1:0]      src_runt   [NUM_PORTS];

    // Only the destination MAC is inspected; the rest of each beat is ignored.
    logic tdata_unused;
    assign tdata_unused = ^mon_tdata;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_chan
        eth_port_stat_chan #(
            .DATA_W     (DATA_W),
            .CNT_W      (CNT_W),
            .BYTE_CNT_W (BYTE_CNT_W),
            .SATURATE   (SATURATE),
            .RUNT_LEN   (RUNT_LEN)
        ) u_chan (
            .axis_aclk    (axis_aclk),
            .axis_aresetn (axis_aresetn),
            .dst_mac      (mon_tdata[p][47:0]),
            .tkeep        (mon_tkeep[p]),
            .tvalid       (mon_tvalid[p]),
            .tready       (mon_tready[p]),
            .tlast        (mon_tlast[p]),
            .cnt_clr      (CntClr),
            .pkt_cnt      (live_pkt[p]),
            .bcast_cnt    (live_bcast[p]),
            .byte_cnt     (live_byte[p]),
            .runt_cnt     (live_runt[p])
        );
    end

`ifdef PKT_STATS_SNAPSHOT_EN
    logic [CNT_W-1:0]      shd_pkt_q   [NUM_PORTS], shd_pkt_d   [NUM_PORTS];
    logic [CNT_W-1:0]      shd_bcast_q [NUM_PORTS], shd_bcast_d [NUM_PORTS];
    logic [BYTE_CNT_W-1:0] shd_byte_q  [NUM_PORTS], shd_byte_d  [NUM_PORTS];
    logic [CNT_W-1:0]      shd_runt_q  [NUM_PORTS], shd_runt_d  [NUM_PORTS];

    // Live counters are sampled before this edge's clear, so snap+CntClr keeps pre-clear values.
    always_comb begin
        shd_pkt_d   = shd_pkt_q;
        shd_bcast_d = shd_bcast_q;
        shd_byte_d  = shd_byte_q;
        shd_runt_d  = shd_runt_q;
        if (snap) begin
            shd_pkt_d   = live_pkt;
            shd_bcast_d = live_bcast;
            shd_byte_d  = live_byte;
            shd_runt_d  = live_runt;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                shd_pkt_q[p]   <= '0;
                shd_bcast_q[p] <= '0;
                shd_byte_q[p]  <= '0;
                shd_runt_q[p]  <= '0;
            end
        end else begin
            shd_pkt_q   <= shd_pkt_d;
            shd_bcast_q <= shd_bcast_d;
            shd_byte_q  <= shd_byte_d;
            shd_runt_q  <= shd_runt_d;
        end
    end

    assign src_pkt   = shd_pkt_q;
    assign src_bcast = shd_bcast_q;
    assign src_byte  = shd_byte_q;
    assign src_runt  = shd_runt_q;
`else
    assign src_pkt   = live_pkt;
    assign src_bcast = live_bcast;
    assign src_byte  = live_byte;
    assign src_runt  = live_runt;
`endif

    logic [ADDR_W-1:0] port_idx;
    stat_sel_e         sel;
    logic [63:0]       rd_mux;
    logic [63:0]       rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    // Unmatched port indices fall through to zero.
    always_comb begin
        port_idx = rd_addr >> 2;
        sel      = stat_sel_e'(rd_addr[1:0]);
        rd_mux   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_idx == ADDR_W'(p)) begin
                case (sel)
                    STAT_PKT:   rd_mux = 64'(src_pkt[p]);
                    STAT_BCAST: rd_mux = 64'(src_bcast[p]);
                    STAT_BYTE:  rd_mux = 64'(src_byte[p]);
                    STAT_RUNT:  rd_mux = 64'(src_runt[p]);
                endcase
            end
        end
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? rd_mux : rd_data_q;
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_eth_port_pkt_stats.sv
// Directed bench: a saturating and a wrapping instance (CNT_W=4, 3 ports) share stimulus.
module tb_eth_port_pkt_stats;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0][63:0] tdata;
    logic [2:0][7:0]  tkeep;
    logic [2:0]       tvalid, tready, tlast;
    logic            cnt_clr, rd_en;
    logic [3:0]      rd_addr;
    logic [63:0]     rd_data_a, rd_data_b;
    logic            rd_valid_a, rd_valid_b;
`ifdef PKT_STATS_SNAPSHOT_EN
    logic            snap;
    bit              auto_snap = 1'b1;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    eth_port_pkt_stats #(.NUM_PORTS(3), .DATA_W(64), .CNT_W(4), .BYTE_CNT_W(48),
                         .SATURATE(1), .RUNT_LEN(64)) u_sat (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .mon_tdata(tdata), .mon_tkeep(tkeep), .mon_tvalid(tvalid),
        .mon_tready(tready), .mon_tlast(tlast), .CntClr(cnt_clr),
`ifdef PKT_STATS_SNAPSHOT_EN
        .snap(snap),
`endif
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    eth_port_pkt_stats #(.NUM_PORTS(3), .DATA_W(64), .CNT_W(4), .BYTE_CNT_W(48),
                         .SATURATE(0), .RUNT_LEN(64)) u_wrap (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .mon_tdata(tdata), .mon_tkeep(tkeep), .mon_tvalid(tvalid),
        .mon_tready(tready), .mon_tlast(tlast), .CntClr(cnt_clr),
`ifdef PKT_STATS_SNAPSHOT_EN
        .snap(snap),
`endif
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic beat(input int p, input logic [63:0] d, input logic [7:0] k, input logic l);
        tdata[p]  = d;
        tkeep[p]  = k;
        tvalid[p] = 1'b1;
        tready[p] = 1'b1;
        tlast[p]  = l;
        tick();
        tvalid[p] = 1'b0;
        tlast[p]  = 1'b0;
    endtask

    // nfull full-keep beats followed by a tlast beat with last_k.
    task automatic frame(input int p, input logic [63:0] first, input int nfull, input logic [7:0] last_k);
        if (nfull == 0) begin
            beat(p, first, last_k, 1'b1);
        end else begin
            beat(p, first, 8'hFF, 1'b0);
            for (int i = 1; i < nfull; i++) beat(p, 64'h0, 8'hFF, 1'b0);
            beat(p, 64'h0, last_k, 1'b1);
        end
        idle(2);
    endtask

    task automatic pulse_snap();
`ifdef PKT_STATS_SNAPSHOT_EN
        snap = 1'b1;
        tick();
        snap = 1'b0;
`endif
    endtask

    task automatic rd_chk(input string tag, input int p, input int sel,
                          input logic [63:0] exp_sat, input logic [63:0] exp_wrap);
`ifdef PKT_STATS_SNAPSHOT_EN
        if (auto_snap) pulse_snap();
`endif
        rd_en   = 1'b1;
        rd_addr = {2'(p), 2'(sel)};
        tick();
        rd_en   = 1'b0;
        check({tag, " vld"}, 64'({rd_valid_a, rd_valid_b}), 64'h3);
        check({tag, " sat"}, rd_data_a, exp_sat);
        check({tag, " wrap"}, rd_data_b, exp_wrap);
    endtask

    initial begin
        rst_n   = 1'b0;
        tdata   = '0;
        tkeep   = '0;
        tvalid  = '0;
        tready  = '1;
        tlast   = '0;
        cnt_clr = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
`ifdef PKT_STATS_SNAPSHOT_EN
        snap    = 1'b0;
`endif
        idle(3);
        check("rst vld", 64'({rd_valid_a, rd_valid_b}), 64'h0);
        check("rst data_a", rd_data_a, 64'h0);
        check("rst data_b", rd_data_b, 64'h0);
        rst_n = 1'b1;
        tick();
        rd_chk("rst p0 pkt", 0, 0, 0, 0);

        // Port 0 unicast, 8+8+4 bytes.
        frame(0, 64'h0000_5544_3322_1100, 2, 8'h0F);
        rd_chk("t1 p0 pkt", 0, 0, 1, 1);
        rd_chk("t1 p0 bcast", 0, 1, 0, 0);
        rd_chk("t1 p0 byte", 0, 2, 20, 20);
        rd_chk("t1 p0 runt", 0, 3, 1, 1);
        rd_chk("t1 p1 pkt", 1, 0, 0, 0);
        rd_chk("t1 p1 byte", 1, 2, 0, 0);

        // Port 1 broadcast, 66 bytes, 2 stalled cycles carrying a bogus tlast.
        beat(1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) beat(1, 64'h0, 8'hFF, 1'b0);
        tvalid[1] = 1'b1; tready[1] = 1'b0; tlast[1] = 1'b1; tkeep[1] = 8'hFF;
        idle(2);
        tvalid[1] = 1'b0; tready[1] = 1'b1; tlast[1] = 1'b0;
        for (int i = 0; i < 4; i++) beat(1, 64'h0, 8'hFF, 1'b0);
        beat(1, 64'h0, 8'h03, 1'b1);
        idle(2);
        rd_chk("t2 p1 bcast", 1, 1, 1, 1);
        rd_chk("t2 p1 byte", 1, 2, 66, 66);
        rd_chk("t2 p1 runt", 1, 3, 0, 0);
        rd_chk("t2 p1 pkt", 1, 0, 1, 1);

        // Runt boundary: 64 bytes is not a runt, 63 is.
        frame(0, 64'h0, 7, 8'hFF);
        frame(0, 64'h0, 7, 8'h7F);
        rd_chk("t3 p0 runt", 0, 3, 2, 2);
        rd_chk("t3 p0 pkt", 0, 0, 3, 3);
        rd_chk("t3 p0 byte", 0, 2, 147, 147);

        rd_chk("t4 oob port", 3, 0, 0, 0);
        rd_en = 1'b1; rd_addr = 4'b00_00;
        tick();
        check("t4 b2b0 vld", 64'(rd_valid_a), 64'h1);
        check("t4 b2b0 data", rd_data_a, 64'd3);
        rd_addr = 4'b01_10;
        tick();
        check("t4 b2b1 vld", 64'(rd_valid_a), 64'h1);
        check("t4 b2b1 data", rd_data_a, 64'd66);
        rd_en = 1'b0;
        tick();
        check("t4 idle vld", 64'(rd_valid_a), 64'h0);
        check("t4 hold data", rd_data_a, 64'd66);

        // Clear, then a completion that lands entirely under clear, then a frame spanning a clear.
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        rd_chk("t5 cleared", 0, 0, 0, 0);
        cnt_clr = 1'b1;
        beat(0, 64'h0, 8'hFF, 1'b1);
        tick();
        cnt_clr = 1'b0;
        idle(2);
        rd_chk("t5 drop pkt", 0, 0, 0, 0);
        rd_chk("t5 drop byte", 0, 2, 0, 0);
        beat(1, 64'h0, 8'hFF, 1'b0);
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        beat(1, 64'h0, 8'hFF, 1'b1);
        idle(2);
        rd_chk("t5 span pkt", 1, 0, 1, 1);
        rd_chk("t5 span byte", 1, 2, 16, 16);
        rd_chk("t5 span bcast", 1, 1, 0, 0);

        // 17 eight-byte frames against 4-bit counters.
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        for (int i = 0; i < 17; i++) beat(0, 64'h0, 8'hFF, 1'b1);
        idle(2);
        rd_chk("t6 pkt", 0, 0, 15, 1);
        rd_chk("t6 runt", 0, 3, 15, 1);
        rd_chk("t6 byte", 0, 2, 136, 136);

`ifdef PKT_STATS_SNAPSHOT_EN
        auto_snap = 1'b0;
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) beat(0, 64'h0, 8'hFF, 1'b1);
        idle(2);
        pulse_snap();
        for (int i = 0; i < 2; i++) beat(0, 64'h0, 8'hFF, 1'b1);
        idle(2);
        rd_chk("t7 snap5", 0, 0, 5, 5);
        pulse_snap();
        rd_chk("t7 snap7", 0, 0, 7, 7);
        snap = 1'b1; cnt_clr = 1'b1;
        tick();
        snap = 1'b0; cnt_clr = 1'b0;
        rd_chk("t7 snap preclr", 0, 0, 7, 7);
        pulse_snap();
        rd_chk("t7 snap postclr", 0, 0, 0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
